// File: rtl/biu_xfer_ctrl.sv
// Burst transfer sequencer for the BIU internal bus: drives MAR/MDR control pins
// and the external memory req/ack handshake, with a per-word ack timeout.
module biu_xfer_ctrl #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             rw,
    input  logic [LEN_W-1:0] len,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mar_oe,
    output logic             mar_inc,
    output logic             mdr_ld,
    output logic             mdr_oe,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_left
);

    // Wide enough to hold TIMEOUT itself, where the counter parks on abort.
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0]  ONE_WORD  = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              rw_lat, rw_lat_nxt;
    logic [LEN_W-1:0]  wl, wl_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              err_q, err_nxt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            rw_lat   <= 1'b0;
            wl       <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            rw_lat   <= rw_lat_nxt;
            wl       <= wl_nxt;
            wait_cnt <= wait_nxt;
            err_q    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rw_lat_nxt = rw_lat;
        wl_nxt     = wl;
        wait_nxt   = wait_cnt;
        err_nxt    = err_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mar_oe     = 1'b0;
        mar_inc    = 1'b0;
        mdr_ld     = 1'b0;
        mdr_oe     = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    err_nxt = 1'b0;
                    if (len != '0) begin
                        rw_lat_nxt = rw;
                        wl_nxt     = len;
                        wait_nxt   = '0;
                        state_nxt  = REQ;
                    end else begin
                        // Empty burst: report completion without touching the bus.
                        state_nxt = DONE;
                    end
                end
            end

            REQ: begin
                mem_req = 1'b1;
                mar_oe  = 1'b1;
                mem_we  = rw_lat;
                mdr_oe  = rw_lat;
                if (mem_ack) begin
                    mar_inc  = 1'b1;
                    mdr_ld   = ~rw_lat;
                    wait_nxt = '0;
                    if (wl != '0)
                        wl_nxt = wl - ONE_WORD;
                    state_nxt = (wl <= ONE_WORD) ? DONE : GAP;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                    // Abort leaves words_left showing how much was not transferred.
                    if (wait_cnt == WAIT_LAST) begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end

            GAP: begin
                state_nxt = REQ;
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy       = (state != IDLE);
    assign err        = err_q;
    assign words_left = wl;

endmodule

// File: tb/tb_biu_xfer_ctrl.sv
// Scoreboard bench for biu_xfer_ctrl: each issued transfer queues its expected
// strobe counts, which are checked when the DUT pulses done.
module tb_biu_xfer_ctrl;

    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 15;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             start = 1'b0;
    logic             rw = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             mem_ack = 1'b0;
    logic             mem_req, mem_we, mar_oe, mar_inc, mdr_ld, mdr_oe;
    logic             busy, done, err;
    logic [LEN_W-1:0] words_left;

    biu_xfer_ctrl #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .rw(rw), .len(len),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mar_oe(mar_oe), .mar_inc(mar_inc), .mdr_ld(mdr_ld), .mdr_oe(mdr_oe),
        .busy(busy), .done(done), .err(err), .words_left(words_left)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int len, n_req, n_ld, n_inc, n_oe, n_we, n_busy, err, wl;
    } xfer_t;

    xfer_t q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int ack_dly  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input int l, input int r, input int ld, input int inc,
                                 input int oe, input int we, input int b, input int e, input int w);
        xfer_t x;
        x.len = l; x.n_req = r; x.n_ld = ld; x.n_inc = inc; x.n_oe = oe;
        x.n_we = we; x.n_busy = b; x.err = e; x.wl = w;
        return x;
    endfunction

    // Memory model: ack arrives ack_dly cycles after mem_req rises (never if negative).
    int  rc = 0;
    logic req_prev = 1'b0;
    always @(posedge Clk) begin
        #1;
        if (mem_req === 1'b1)
            rc = req_prev ? rc + 1 : 0;
        req_prev = (mem_req === 1'b1);
        mem_ack  = req_prev && (ack_dly >= 0) && (rc == ack_dly);
    end

    // Monitor: accumulate strobe counts per burst, check invariants, score on done.
    int c_req, c_ld, c_inc, c_oe, c_we, c_busy, cur_wl;
    logic first_cyc = 1'b1;
    always @(negedge Clk) begin
        if (busy !== 1'b1) begin
            c_req = 0; c_ld = 0; c_inc = 0; c_oe = 0; c_we = 0; c_busy = 0;
            first_cyc = 1'b1;
            check_eq("idle_strobes", 32'({mem_req, mem_we, mar_oe, mar_inc, mdr_ld, mdr_oe, done}), 32'd0);
        end else begin
            if (first_cyc && q.size() > 0) cur_wl = q[0].len;
            first_cyc = 1'b0;
            c_busy++;
            c_req += int'(mem_req);
            c_ld  += int'(mdr_ld);
            c_inc += int'(mar_inc);
            c_oe  += int'(mdr_oe);
            c_we  += int'(mem_we);
            check_eq("ld_oe_excl", 32'(mdr_ld & mdr_oe), 32'd0);
            if (mar_inc) begin
                check_eq("inc_with_ack", 32'(mem_req & mem_ack), 32'd1);
                check_eq("wl_step", 32'(words_left), 32'(cur_wl));
                cur_wl--;
            end
            if (mdr_ld) check_eq("ld_with_ack", 32'(mem_ack), 32'd1);
            if (done) begin
                if (q.size() == 0) begin
                    check_eq("unexpected_done", 32'd1, 32'd0);
                end else begin
                    xfer_t e;
                    e = q.pop_front();
                    check_eq("n_req",  32'(c_req),  32'(e.n_req));
                    check_eq("n_ld",   32'(c_ld),   32'(e.n_ld));
                    check_eq("n_inc",  32'(c_inc),  32'(e.n_inc));
                    check_eq("n_oe",   32'(c_oe),   32'(e.n_oe));
                    check_eq("n_we",   32'(c_we),   32'(e.n_we));
                    check_eq("n_busy", 32'(c_busy), 32'(e.n_busy));
                    check_eq("err_at_done", 32'(err), 32'(e.err));
                    check_eq("wl_at_done", 32'(words_left), 32'(e.wl));
                    n_done++;
                end
            end
        end
    end

    task automatic issue(input logic rw_i, input int len_i, input xfer_t e);
        @(posedge Clk); #1;
        start = 1'b1; rw = rw_i; len = LEN_W'(len_i);
        q.push_back(e);
        @(posedge Clk); #1;
        start = 1'b0;
        @(negedge Clk);
        check_eq("first_req", 32'(mem_req), 32'(len_i != 0));
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 300 && n_done < target; i++) @(negedge Clk);
        check_eq("done_seen", 32'(n_done >= target), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, 32'({mem_req, mem_we, mar_oe, mar_inc, mdr_ld, mdr_oe, busy, done, err}), 32'd0);
        check_eq({tag, "_wl"}, 32'(words_left), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check_all_zero("reset_state");

        // Read burst, ack in the third cycle of each request.
        ack_dly = 2;
        issue(1'b0, 3, mk(3, 9, 3, 3, 0, 0, 12, 0, 0));
        wait_done(1);

        // Single write, immediate ack.
        ack_dly = 0;
        issue(1'b1, 1, mk(1, 1, 0, 1, 1, 1, 2, 0, 0));
        wait_done(2);

        // Zero-length request completes without bus activity.
        issue(1'b0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        wait_done(3);

        // Reset during the second REQ of a 4-word read.
        ack_dly = 1;
        issue(1'b0, 4, mk(4, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 50 && mar_inc !== 1'b1; i++) @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        check_eq("second_req", 32'(mem_req), 32'd1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        q.delete();
        @(negedge Clk);
        check_all_zero("mid_reset");
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check_eq("no_done_after_reset", 32'(done), 32'd0);
        end
        ack_dly = 0;
        issue(1'b0, 2, mk(2, 2, 2, 2, 0, 0, 4, 0, 0));
        wait_done(4);

        // Start pulse during GAP must be ignored.
        issue(1'b0, 2, mk(2, 2, 2, 2, 0, 0, 4, 0, 0));
        for (int i = 0; i < 20 && !(busy === 1'b1 && mem_req === 1'b0 && done === 1'b0); i++)
            @(negedge Clk);
        start = 1'b1; rw = 1'b1; len = LEN_W'(5);
        @(posedge Clk); #1;
        start = 1'b0;
        wait_done(5);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check_eq("no_second_xfer", 32'(busy), 32'd0);
        end
        check_eq("queue_empty", 32'(q.size()), 32'd0);

        // Ack timeout: abort with err, err sticky until the next accepted start.
        ack_dly = -1;
        issue(1'b0, 2, mk(2, TIMEOUT, 0, 0, 0, 0, TIMEOUT + 1, 1, 2));
        wait_done(6);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_eq("err_sticky", 32'(err), 32'd1);
        end
        ack_dly = 0;
        issue(1'b1, 2, mk(2, 2, 0, 2, 2, 2, 4, 0, 0));
        check_eq("err_cleared", 32'(err), 32'd0);
        wait_done(7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/biu_xfer_ctrl.md
Name: biu_xfer_ctrl

Overview:
- Control end of the bus interface unit's shared 32-bit internal bus.
- Sequences burst memory reads and writes using the bus registers' control pins: ld, oe and inc on the address register (MAR) and the data register (MDR).
- Runs a req/ack handshake with external memory, counts remaining words and enforces a per-word ack timeout.
- Sits between the execution unit's transfer request and the MAR/MDR register instances.

Parameters:
- LEN_W, 4, width of burst length and word counter (max burst 2^LEN_W-1 words).
- TIMEOUT, 15, max cycles in REQ without mem_ack before abort (1..255).

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  transfer request; sampled only in IDLE.
- rw  in  1  1 = write (MDR drives bus), 0 = read (MDR loads from bus); latched with start.
- len  in  LEN_W  number of words; latched with start.
- mem_ack  in  1  memory acknowledge for current word.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, valid while mem_req=1.
- mar_oe  out  1  MAR output enable onto address bus.
- mar_inc  out  1  MAR increment.
- mdr_ld  out  1  MDR load from data bus.
- mdr_oe  out  1  MDR output enable onto data bus.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  timeout flag; sticky until next accepted start or Reset.
- words_left  out  LEN_W  remaining words in current burst.

Behaviour:
- Reset (synchronous, Clk edge with Reset=1):
  - state=IDLE, words_left=0, wait counter=0, err=0, latched rw=0.
  - All outputs 0. Reset overrides any in-flight burst. No done pulse is emitted for an aborted burst.
- States: IDLE, REQ, GAP, DONE. Outputs are decoded combinationally from state, latched rw and mem_ack.
- IDLE:
  - All strobes 0.
  - start=1, len!=0: latch rw; words_left<=len; wait<=0; err<=0; go to REQ.
  - start=1, len==0: err<=0; go to DONE (no bus activity).
  - start=0: stay.
- REQ:
  - mem_req=1, mar_oe=1, mem_we=rw, mdr_oe=rw.
  - mem_ack=1 (same cycle):
    - mar_inc=1; mdr_ld=~rw; words_left<=words_left-1; wait<=0.
    - If words_left==1, go to DONE; else go to GAP.
  - mem_ack=0: wait<=wait+1.
    - If wait==TIMEOUT-1, err<=1 and go to DONE. words_left holds its value at the abort.
- GAP:
  - One cycle with all strobes 0, so mem_req drops between words. mem_ack ignored.
  - Go to REQ.
- DONE: done=1 for exactly one cycle; go to IDLE.
- busy = (state != IDLE).
- start outside IDLE is ignored; it is not queued.
- mem_ack outside REQ is ignored.
- Strobe exclusivity (invariants):
  - mdr_ld and mdr_oe are never both 1.
  - mar_inc=1 only in a REQ cycle with mem_ack=1.
- Latency:
  - First mem_req one cycle after start is sampled.
  - Minimum burst of N words, ack immediate every word: 2N+1 cycles from start edge to the done cycle inclusive.
- Arithmetic: words_left is unsigned LEN_W-bit and never decrements below 0. The wait counter is sized ceil(log2(TIMEOUT+1)) and saturates at abort.

Test Plan:
- Read burst:
  - Stimulus: start, rw=0, len=3; mem_ack high 2 cycles after each mem_req rise.
  - Required: three REQ phases separated by 1-cycle GAPs; exactly 3 mdr_ld and 3 mar_inc pulses, each coincident with mem_ack; mdr_oe=0 and mem_we=0 throughout; words_left 3->2->1->0; one done pulse; err=0.
- Single write:
  - Stimulus: start, rw=1, len=1; mem_ack immediate.
  - Required: mem_req=mem_we=mdr_oe=mar_oe=1 for 1 cycle; mar_inc=1; mdr_ld=0; done on the next cycle; busy high exactly 2 cycles.
- Zero length:
  - Stimulus: start with len=0.
  - Required: no mem_req, no strobes; done pulses the next cycle; busy high 1 cycle.
- Timeout:
  - Stimulus: start rw=0 len=2; mem_ack never asserted.
  - Required: mem_req high exactly 15 cycles; then done=1 and err=1; words_left=2; err remains 1 in IDLE until the next start is accepted, which clears it.
- Reset mid-burst:
  - Stimulus: assert Reset during the second REQ of a len=4 read.
  - Required: next edge gives all outputs 0, state IDLE, words_left=0; no done pulse; a new start then proceeds normally.
- Start while busy:
  - Stimulus: pulse start (len=5) during GAP of a len=2 burst.
  - Required: the pulse is ignored; the burst completes after 2 words; no second transfer begins without a fresh start in IDLE.
